// File: rtl/epp_i2c_pkg.sv
// Shared constants and types for the EPP/codec I2C master.
package epp_i2c_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CMD    = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  localparam int CMD_START   = 0;
  localparam int CMD_STOP    = 1;
  localparam int CMD_WRITE   = 2;
  localparam int CMD_READ    = 3;
  localparam int CMD_ACK_OUT = 4;

  localparam int ST_BUSY = 0;
  localparam int ST_NACK = 1;
  localparam int ST_HELD = 2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_BIT, S_STOP} state_t;

  typedef logic [1:0] phase_t;

endpackage

// File: rtl/epp_i2c_tick_gen.sv
// Quarter-SCL-period tick divider; while hold is set it parks on the terminal count.
module epp_i2c_tick_gen #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic hold,
  output logic tick
);

  localparam logic [15:0] TERM = 16'(CLK_DIV - 1);

  logic [15:0] div;

  assign tick = en && (div == TERM) && !hold;

  // Holding only at terminal count absorbs the synchronizer lag after SCL release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div <= '0;
    end else if (!en) begin
      div <= '0;
    end else if (div == TERM) begin
      if (!hold) div <= '0;
    end else begin
      div <= div + 16'd1;
    end
  end

endmodule

// File: rtl/epp_i2c_master.sv
// Avalon-MM byte-level I2C master: START, 8 data bits + ACK, STOP on open-drain pads.
// state   | meaning
// IDLE    | waiting for a CMD write
// START   | (repeated) START condition, 4 phases
// BIT     | 9 bit slots (8 data + ACK), 4 phases each
// STOP    | STOP condition, 4 phases
module epp_i2c_master import epp_i2c_pkg::*; #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe
);

  state_t      state, nxt_stage;
  phase_t      phase;
  logic [3:0]  slot;
  logic [7:0]  tx, shreg, rx;
  logic        busy, nack, bus_held;
  logic        op_write, op_read, op_stop, ack_out;
  logic [1:0]  scl_s, sda_s;
  logic        scl_sync, sda_sync;
  logic        wr, accept, tick, hold, stage_end;
  logic        c_w, c_r, c_s;
  logic        unused_wd;

  assign unused_wd = ^writedata[31:8];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
    end else begin
      scl_s <= {scl_s[0], scl_in};
      sda_s <= {sda_s[0], sda_in};
    end
  end

  assign scl_sync = scl_s[1];
  assign sda_sync = sda_s[1];

  assign wr        = chipselect && !write_n;
  assign accept    = wr && (address == ADDR_CMD) && !busy && (|writedata[3:0]);
  assign hold      = busy && !scl_oe && !scl_sync;
  assign stage_end = tick && (phase == 2'd3) && (state != S_BIT || slot == 4'd8);

  epp_i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (busy),
    .hold    (hold),
    .tick    (tick)
  );

  always_comb begin
    c_w = (state == S_IDLE) ? writedata[CMD_WRITE] : op_write;
    c_r = (state == S_IDLE) ? (writedata[CMD_READ] & ~writedata[CMD_WRITE]) : op_read;
    c_s = (state == S_IDLE) ? writedata[CMD_STOP] : op_stop;
    nxt_stage = S_IDLE;
    case (state)
      S_IDLE:  nxt_stage = writedata[CMD_START] ? S_START :
                           (c_w | c_r) ? S_BIT : c_s ? S_STOP : S_IDLE;
      S_START: nxt_stage = (c_w | c_r) ? S_BIT : c_s ? S_STOP : S_IDLE;
      S_BIT:   nxt_stage = c_s ? S_STOP : S_IDLE;
      default: nxt_stage = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx <= '0;
    else if (wr && address == ADDR_DATA) tx <= writedata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      phase    <= '0;
      slot     <= '0;
      busy     <= 1'b0;
      nack     <= 1'b0;
      bus_held <= 1'b0;
      rx       <= '0;
      shreg    <= '0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      op_write <= 1'b0;
      op_read  <= 1'b0;
      op_stop  <= 1'b0;
      ack_out  <= 1'b0;
    end else if (accept || stage_end) begin
      state <= nxt_stage;
      phase <= '0;
      slot  <= '0;
      if (state == S_START) bus_held <= 1'b1;
      if (state == S_STOP)  bus_held <= 1'b0;
      case (nxt_stage)
        // SCL stays low into a repeated START so SDA can be released safely.
        S_START: begin scl_oe <= bus_held; sda_oe <= 1'b0; end
        S_BIT:   begin scl_oe <= 1'b1; sda_oe <= c_w ? ~tx[7] : 1'b0; shreg <= tx; end
        S_STOP:  begin scl_oe <= 1'b1; sda_oe <= 1'b1; end
        default: busy <= 1'b0;
      endcase
      if (accept) begin
        busy     <= 1'b1;
        op_write <= writedata[CMD_WRITE];
        op_read  <= writedata[CMD_READ] & ~writedata[CMD_WRITE];
        op_stop  <= writedata[CMD_STOP];
        ack_out  <= writedata[CMD_ACK_OUT];
      end
    end else if (tick) begin
      phase <= phase + 2'd1;
      case (state)
        S_START: case (phase)
          2'd0:    scl_oe <= 1'b0;
          2'd1:    sda_oe <= 1'b1;
          2'd2:    scl_oe <= 1'b1;
          default: ;
        endcase
        S_BIT: case (phase)
          2'd1: scl_oe <= 1'b0;
          2'd2: begin
            if (slot == 4'd8) begin
              if (op_write) nack <= sda_sync;
            end else if (!op_write) begin
              rx <= {rx[6:0], sda_sync};
            end
          end
          2'd3: begin
            slot   <= slot + 4'd1;
            scl_oe <= 1'b1;
            shreg  <= {shreg[6:0], 1'b0};
            sda_oe <= (slot == 4'd7) ? (op_write ? 1'b0 : ~ack_out)
                                     : (op_write ? ~shreg[6] : 1'b0);
          end
          default: ;
        endcase
        S_STOP: case (phase)
          2'd0:    scl_oe <= 1'b0;
          2'd2:    sda_oe <= 1'b0;
          default: ;
        endcase
        default: ;
      endcase
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[7:0] = rx;
      ADDR_STATUS: begin
        readdata[ST_BUSY] = busy;
        readdata[ST_NACK] = nack;
        readdata[ST_HELD] = bus_held;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_epp_i2c_master.sv
// Directed bench for epp_i2c_master with a small open-drain slave model on the pads.
module tb_epp_i2c_master;
  import epp_i2c_pkg::*;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        scl_in, sda_in, scl_oe, sda_oe;

  int errors = 0;
  int checks = 0;

  // slave model state
  logic [9:0] slv_pat = '0;
  logic       slv_sda = 1'b0;
  logic       hold_act = 1'b0;
  logic       stretch_arm = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_oe = 1'b0;
  logic       scl_now, sda_now;
  int         hold_cnt = 0;
  int         fall_cnt = 0;
  int         rise_cnt = 0;
  int         cyc = 0;
  logic       rise_sda [16];
  int         rise_cyc [16];

  assign scl_in = !(scl_oe || hold_act);
  assign sda_in = !(sda_oe || slv_sda);

  always #5 clk = ~clk;

  epp_i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe)
  );

  // Slave: drives slv_pat[k] on the k-th SCL fall, optionally stretches one SCL release.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (hold_cnt > 0) hold_cnt = hold_cnt - 1;
    if (stretch_arm && rise_cnt == 3 && prev_oe && !scl_oe) begin
      hold_cnt = 50;
      stretch_arm = 1'b0;
    end
    hold_act = (hold_cnt > 0);
    scl_now  = !(scl_oe || hold_act);
    sda_now  = !(sda_oe || slv_sda);
    if (scl_now && !prev_scl && rise_cnt < 16) begin
      rise_sda[rise_cnt] = sda_now;
      rise_cyc[rise_cnt] = cyc;
      rise_cnt = rise_cnt + 1;
    end
    if (!scl_now && prev_scl) begin
      slv_sda  = (fall_cnt < 10) ? slv_pat[fall_cnt] : 1'b0;
      fall_cnt = fall_cnt + 1;
    end
    prev_scl = scl_now;
    prev_oe  = scl_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; address = ADDR_STATUS;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1 d = readdata;
    address = ADDR_STATUS;
  endtask

  task automatic start_xfer(input logic [7:0] data, input logic [31:0] cmd,
                            input logic [9:0] pat, input logic stretch);
    rise_cnt = 0; fall_cnt = 0; slv_pat = pat; stretch_arm = stretch;
    bus_write(ADDR_DATA, {24'd0, data});
    bus_write(ADDR_CMD, cmd);
  endtask

  // Counts busy cycles from the current one until busy drops (bounded).
  task automatic wait_done(output int n);
    n = 0;
    address = ADDR_STATUS;
    for (int i = 0; i < 2000; i++) begin
      #1;
      if (readdata[ST_BUSY]) n++;
      else break;
      @(negedge clk);
    end
  endtask

  function automatic logic [7:0] rise_byte();
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[7-k] = rise_sda[k];
    return b;
  endfunction

  logic [31:0] rd;
  int          n;
  logic [9:0]  rpat;
  logic [7:0]  rbyte;
  logic        ok;

  initial begin
    // reset
    #2;
    check("reset_lines", {30'd0, scl_oe, sda_oe}, 32'd0);
    read_reg(ADDR_STATUS, rd);
    check("reset_status", rd, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    read_reg(ADDR_STATUS, rd);
    check("idle_status", rd, 32'd0);
    check("idle_lines", {30'd0, scl_oe, sda_oe}, 32'd0);
    read_reg(ADDR_DATA, rd);
    check("reset_rx", rd, 32'd0);
    read_reg(2'd3, rd);
    check("addr3_zero", rd, 32'd0);

    // CMD with no valid operation bit
    bus_write(ADDR_CMD, 32'h10);
    read_reg(ADDR_STATUS, rd);
    check("noop_cmd_busy", rd, 32'd0);
    read_reg(ADDR_CMD, rd);
    check("cmd_reads_zero", rd, 32'd0);

    // START + WRITE 0xA0 + STOP, slave ACKs (pulls SDA on fall 8)
    start_xfer(8'hA0, 32'h07, 10'h100, 1'b0);
    wait_done(n);
    check("wr_busy_len", n, 32'd176);
    check("wr_rise_count", rise_cnt, 32'd10);
    check("wr_sda_bits", {24'd0, rise_byte()}, 32'hA0);
    check("wr_ack_level", {31'd0, rise_sda[8]}, 32'd0);
    check("wr_stop_sda_low", {31'd0, rise_sda[9]}, 32'd0);
    check("wr_bit_period", rise_cyc[7] - rise_cyc[6], 32'd16);
    read_reg(ADDR_STATUS, rd);
    check("wr_status", rd, 32'd0);
    check("wr_lines_released", {30'd0, scl_oe, sda_oe}, 32'd0);

    // same transfer, nobody ACKs
    start_xfer(8'hA0, 32'h07, 10'h000, 1'b0);
    wait_done(n);
    check("nack_busy_len", n, 32'd176);
    check("nack_ack_level", {31'd0, rise_sda[8]}, 32'd1);
    check("nack_stop_rise", rise_cnt, 32'd10);
    check("nack_stop_sda_low", {31'd0, rise_sda[9]}, 32'd0);
    read_reg(ADDR_STATUS, rd);
    check("nack_status", rd, 32'h2);
    check("nack_lines_released", {30'd0, scl_oe, sda_oe}, 32'd0);

    // READ + ACK_OUT=1 + STOP, slave returns 0x5A
    rbyte = 8'h5A;
    rpat = '0;
    for (int k = 0; k < 8; k++) rpat[k] = ~rbyte[7-k];
    start_xfer(8'h00, 32'h1A, rpat, 1'b0);
    wait_done(n);
    check("rd_busy_len", n, 32'd160);
    read_reg(ADDR_DATA, rd);
    check("rd_data", rd, 32'h5A);
    check("rd_line_bits", {24'd0, rise_byte()}, 32'h5A);
    check("rd_ack_released", {31'd0, rise_sda[8]}, 32'd1);
    check("rd_rise_count", rise_cnt, 32'd10);
    read_reg(ADDR_STATUS, rd);
    check("rd_status_keeps_nack", rd, 32'h2);

    // clock stretch: slave holds SCL low 50 cycles at release of bit 3
    start_xfer(8'hA0, 32'h07, 10'h100, 1'b1);
    wait_done(n);
    check("str_busy_len_range", {31'd0, (n >= 224 && n <= 228)}, 32'd1);
    check("str_bit3_delay", {31'd0, (rise_cyc[3] - rise_cyc[2]) >= 64}, 32'd1);
    check("str_later_period", rise_cyc[6] - rise_cyc[5], 32'd16);
    check("str_ack_period", rise_cyc[8] - rise_cyc[7], 32'd16);
    check("str_sda_bits", {24'd0, rise_byte()}, 32'hA0);
    read_reg(ADDR_STATUS, rd);
    check("str_status", rd, 32'd0);

    // CMD write while busy is ignored
    start_xfer(8'hA0, 32'h07, 10'h100, 1'b0);
    repeat (40) @(negedge clk);
    bus_write(ADDR_CMD, 32'h0B);
    wait_done(n);
    check("busy_cmd_len", n + 42, 32'd176);
    check("busy_cmd_bits", {24'd0, rise_byte()}, 32'hA0);
    check("busy_cmd_rises", rise_cnt, 32'd10);
    read_reg(ADDR_STATUS, rd);
    check("busy_cmd_status", rd, 32'd0);

    // reset during bit 5 (SCL low, SDA driven low for a 0 data bit)
    start_xfer(8'h00, 32'h07, 10'h100, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (fall_cnt >= 6) begin ok = 1'b1; break; end
    end
    check("rst_reach_bit5", {31'd0, ok}, 32'd1);
    #2;
    check("rst_pre_lines", {30'd0, scl_oe, sda_oe}, 32'd3);
    reset_n = 1'b0;
    #1;
    check("rst_lines_released", {30'd0, scl_oe, sda_oe}, 32'd0);
    read_reg(ADDR_STATUS, rd);
    check("rst_status", rd, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    read_reg(ADDR_STATUS, rd);
    check("rst_stays_idle", rd, 32'd0);
    check("rst_idle_lines", {30'd0, scl_oe, sda_oe}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/epp_i2c_master.md
# epp_i2c_master

Byte-level I2C master controller for the EPP/audio-codec I2C bus, replacing software bit-banging of the SCL/SDA PIOs. It is an Avalon-MM slave on the Nios II data bus: software writes a byte and a command, and the block sequences START, 8 data bits, ACK and STOP on open-drain SCL/SDA pads. It supports repeated START and slave clock stretching.

## Interface
- CLK_DIV, 125: clk cycles per quarter SCL period (50 MHz / (4 × 125) = 100 kHz). Legal range 2..65535.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, zero wait states; unused bits 0.
- scl_in  in  1  SCL pad input.
- sda_in  in  1  SDA pad input.
- scl_oe  out  1  1 = drive SCL low, 0 = release.
- sda_oe  out  1  1 = drive SDA low, 0 = release.

## Operation
- Registers:
  - addr 0 DATA: write [7:0] = tx byte; read [7:0] = last rx byte.
  - addr 1 CMD, write only, reads 0: bit0 START, bit1 STOP, bit2 WRITE, bit3 READ, bit4 ACK_OUT (level sent in the ACK slot of a READ; 0 = ACK).
  - addr 2 STATUS, read only: bit0 busy, bit1 nack (ACK slot level sampled on last WRITE), bit2 bus_held (set by START, cleared by STOP).
  - addr 3: reads 0, writes ignored.
- CMD writes while busy=1 are ignored. A CMD write with no valid bit does not set busy. DATA writes are always accepted; tx byte is latched into the shift register when the WRITE phase begins.
- One CMD write runs in fixed order: START → WRITE or READ → STOP. If WRITE and READ are both set, WRITE wins and READ is dropped.
- FSM states: IDLE, START, BIT, STOP. Each state has phases 0–3; each phase lasts one tick.
  - START: p0 release SDA; p1 release SCL; p2 drive SDA low; p3 drive SCL low. Because p0 runs with SCL low, START also works as a repeated START.
  - BIT: 9 bit slots, MSB first, slot 8 = ACK. Per slot: p0 SCL low and set SDA; p1 hold; p2 release SCL; p3 SCL high.
    - WRITE: SDA carries data bits in slots 0–7 and is released in slot 8.
    - READ: SDA is released in slots 0–7 and carries ACK_OUT in slot 8.
    - Sampling: sync SDA is sampled at the p2→p3 transition. The ACK slot sample goes to nack; READ data bits shift into rx.
  - STOP: p0 SCL low, SDA low; p1 release SCL; p2 hold; p3 release SDA.
- Clock stretching: in any phase that releases SCL, the tick counter is held until synchronized scl_in = 1.
- scl_in and sda_in pass through 2-flop synchronizers with reset value 1.
- Reset values: scl_oe=0, sda_oe=0, busy=0, nack=0, bus_held=0, rx=0, tx=0, FSM=IDLE, divider=0.

## Timing
- busy rises the cycle after the accepted CMD write and falls the cycle after the final phase of the last stage.
- First tick occurs CLK_DIV cycles after busy rises. A tick fires when the divider reaches CLK_DIV−1; the divider then wraps to 0.
- Stage durations, no stretching:
  - START = 4 ticks.
  - BYTE = 36 ticks.
  - STOP = 4 ticks.
  - START+WRITE+STOP = 44 × CLK_DIV cycles.
- scl_oe and sda_oe are registered and change on the cycle of the tick that ends the previous phase.
- reset_n asserted mid-transfer releases both lines immediately (asynchronous) and aborts the transfer; no STOP is generated.
- A STATUS read in the same cycle that busy falls returns the post-update value, including nack and rx.

## Structure
- Package epp_i2c_pkg holds:
  - register address constants;
  - CMD/STATUS bit indices;
  - the FSM state enum;
  - the 2-bit phase type.
- Sub-module epp_i2c_tick_gen contains the CLK_DIV divider with a hold input (driven by the stretch condition) and a tick output. The FSM, shift registers and register file stay in the top level.

## Test plan
- Reset → scl_oe=sda_oe=0 and STATUS=0. After release, one idle cycle → still 0.
- CLK_DIV=4: DATA=0xA0, CMD=0x07, slave ACKs → SDA sequence 1,0,1,0,0,0,0,0 on SCL rising edges, then STATUS=0 and busy high for 176 cycles.
- Same transfer with SDA floating high in the ACK slot → STATUS.nack=1 and the STOP still generated.
- CMD=0x1A (READ, ACK_OUT=1, STOP) with slave driving 0x5A → DATA reads 0x5A, master leaves SDA released in the ACK slot, then STOP.
- Hold scl_in low for 50 cycles after p2 of bit 3 → SCL high phase delayed by ≥50 cycles, and the remaining bit timings are unchanged.
- CMD write while busy=1 is ignored, so the transfer completes unchanged. Asserting reset_n during bit 5 releases both lines in the same cycle and gives busy=0.
